cnn_layer_accel_job_driver: RTL and testbench

- Host-side driver for one cnn_layer_accel_quad job; it sits on the opposite side of the job/pixel interface.
- Accepts a job descriptor and starts the job with the job_start handshake.
- On each job_fetch_request it acknowledges, then streams one input row of pixel vectors from a linear input-map memory.
- Closes the job with job_complete_ack; runs entirely in the interface clock domain.

---
 rtl/cnn_layer_accel_job_driver.sv | 193 +++++++++++++++++++
 tb/tb_cnn_layer_accel_job_driver.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_job_driver.sv
// Host-side job driver for one cnn_layer_accel_quad job.
// Takes a job descriptor, raises job_start, answers each row fetch request
// by streaming one row of pixel vectors out of a linear input-map memory,
// and closes the job with job_complete_ack / job_done.
module cnn_layer_accel_job_driver #(
  parameter int unsigned C_PIXEL_WIDTH  = 16,
  parameter int unsigned C_NUM_CHANNELS = 8,
  parameter int unsigned C_ADDR_WIDTH   = 20,
  parameter int unsigned C_DIM_WIDTH    = 10
) (
  input  logic                                    clk_if,
  input  logic                                    rst,
  input  logic                                    cmd_valid,
  output logic                                    cmd_ready,
  input  logic [C_DIM_WIDTH-1:0]                  cmd_num_rows,
  input  logic [C_DIM_WIDTH-1:0]                  cmd_num_cols,
  input  logic [C_ADDR_WIDTH-1:0]                 cmd_base_addr,
  output logic                                    job_start,
  input  logic                                    job_accept,
  input  logic                                    job_fetch_request,
  output logic                                    job_fetch_ack,
  output logic                                    job_fetch_complete,
  input  logic                                    job_complete,
  output logic                                    job_complete_ack,
  output logic                                    pixel_valid,
  input  logic                                    pixel_ready,
  output logic [C_PIXEL_WIDTH*C_NUM_CHANNELS-1:0] pixel_data,
  output logic                                    mem_rd_en,
  output logic [C_ADDR_WIDTH-1:0]                 mem_rd_addr,
  input  logic [C_PIXEL_WIDTH*C_NUM_CHANNELS-1:0] mem_rd_data,
  output logic                                    job_done,
  output logic                                    err_overfetch
);

  localparam int unsigned C_DATA_WIDTH = C_PIXEL_WIDTH * C_NUM_CHANNELS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_REQ,
    S_ACK,
    S_STREAM,
    S_FCOMP,
    S_CACK
  } state_t;

  state_t                  state;
  logic [C_DIM_WIDTH-1:0]  num_rows;
  logic [C_DIM_WIDTH-1:0]  num_cols;
  logic [C_DIM_WIDTH-1:0]  rows_sent;
  logic [C_DIM_WIDTH-1:0]  rd_issued;
  logic [C_DIM_WIDTH-1:0]  beats_sent;
  logic [C_ADDR_WIDTH-1:0] rd_ptr;

  // 2-entry prefetch FIFO fed by the 1-cycle-latency memory
  logic [C_DATA_WIDTH-1:0] fifo_mem [2];
  logic                    fifo_wr_idx;
  logic                    fifo_rd_idx;
  logic [1:0]              fifo_cnt;
  logic                    rd_inflight;

  logic                    pop;
  logic                    issue;
  logic                    rd_phase;
  logic [1:0]              occ_after_pop;

  assign pixel_valid = (fifo_cnt != 2'd0);
  assign pixel_data  = fifo_mem[fifo_rd_idx];
  assign mem_rd_en   = issue;
  assign mem_rd_addr = rd_ptr;

  // Read-issue decision. Issuing already in the ACK cycle and counting the
  // pixel popped this cycle as free is what lets the 2-deep FIFO sustain
  // one pixel per cycle with a 2-cycle startup.
  always_comb begin
    pop           = pixel_valid && pixel_ready;
    rd_phase      = (state == S_ACK) || (state == S_STREAM);
    occ_after_pop = fifo_cnt - {1'b0, pop};
    issue         = rd_phase && (rd_issued < num_cols) &&
                    ((occ_after_pop + {1'b0, rd_inflight}) < 2'd2);
  end

  // Job control FSM with registered handshake outputs and row/read counters
  always_ff @(posedge clk_if) begin
    if (rst) begin
      state              <= S_IDLE;
      cmd_ready          <= 1'b1;
      job_start          <= 1'b0;
      job_fetch_ack      <= 1'b0;
      job_fetch_complete <= 1'b0;
      job_complete_ack   <= 1'b0;
      job_done           <= 1'b0;
      err_overfetch      <= 1'b0;
      num_rows           <= '0;
      num_cols           <= '0;
      rows_sent          <= '0;
      rd_issued          <= '0;
      beats_sent         <= '0;
      rd_ptr             <= '0;
    end else begin
      // Rows are contiguous in memory, so the running pointer left after one
      // row is already the start of the next one.
      if (issue) begin
        rd_ptr    <= rd_ptr + C_ADDR_WIDTH'(1);
        rd_issued <= rd_issued + C_DIM_WIDTH'(1);
      end
      if (pop) begin
        beats_sent <= beats_sent + C_DIM_WIDTH'(1);
      end
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            num_rows      <= cmd_num_rows;
            num_cols      <= cmd_num_cols;
            rd_ptr        <= cmd_base_addr;
            rows_sent     <= '0;
            err_overfetch <= 1'b0;
            cmd_ready     <= 1'b0;
            job_start     <= 1'b1;
            state         <= S_START;
          end
        end
        S_START: begin
          if (job_accept) begin
            job_start <= 1'b0;
            state     <= S_WAIT_REQ;
          end
        end
        S_WAIT_REQ: begin
          if (job_complete) begin
            job_complete_ack <= 1'b1;
            job_done         <= 1'b1;
            state            <= S_CACK;
          end else if (job_fetch_request) begin
            if (rows_sent < num_rows) begin
              job_fetch_ack <= 1'b1;
              rd_issued     <= '0;
              beats_sent    <= '0;
              state         <= S_ACK;
            end else begin
              err_overfetch <= 1'b1;
            end
          end
        end
        S_ACK: begin
          job_fetch_ack <= 1'b0;
          state         <= S_STREAM;
        end
        S_STREAM: begin
          if (pop && (beats_sent == num_cols - C_DIM_WIDTH'(1))) begin
            job_fetch_complete <= 1'b1;
            state              <= S_FCOMP;
          end
        end
        S_FCOMP: begin
          job_fetch_complete <= 1'b0;
          rows_sent          <= rows_sent + C_DIM_WIDTH'(1);
          state              <= S_WAIT_REQ;
        end
        S_CACK: begin
          job_complete_ack <= 1'b0;
          job_done         <= 1'b0;
          cmd_ready        <= 1'b1;
          state            <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Prefetch FIFO: capture returning read data, advance head on transfer
  always_ff @(posedge clk_if) begin
    if (rst) begin
      rd_inflight <= 1'b0;
      fifo_cnt    <= '0;
      fifo_wr_idx <= 1'b0;
      fifo_rd_idx <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      rd_inflight <= issue;
      if (rd_inflight) begin
        fifo_mem[fifo_wr_idx] <= mem_rd_data;
        fifo_wr_idx           <= ~fifo_wr_idx;
      end
      if (pop) begin
        fifo_rd_idx <= ~fifo_rd_idx;
      end
      fifo_cnt <= fifo_cnt + {1'b0, rd_inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_job_driver.sv
// Directed testbench for cnn_layer_accel_job_driver: plays the accelerator
// side of the job/pixel interface and a 1-cycle-latency input-map memory.
module tb_cnn_layer_accel_job_driver;

  localparam int DW = 128;
  localparam int AW = 20;
  localparam int NW = 10;

  logic          clk_if = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [NW-1:0] cmd_num_rows = '0;
  logic [NW-1:0] cmd_num_cols = '0;
  logic [AW-1:0] cmd_base_addr = '0;
  logic          job_start;
  logic          job_accept = 1'b0;
  logic          job_fetch_request = 1'b0;
  logic          job_fetch_ack;
  logic          job_fetch_complete;
  logic          job_complete = 1'b0;
  logic          job_complete_ack;
  logic          pixel_valid;
  logic          pixel_ready = 1'b0;
  logic [DW-1:0] pixel_data;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          job_done;
  logic          err_overfetch;

  int n_cmp = 0;
  int n_err = 0;

  // results gathered by the stimulus helpers
  logic [AW-1:0] rd_log [$];
  logic [DW-1:0] beat_q [$];
  int            beat_k_q [$];
  int r_ack_k, r_ack_cnt, r_valid_k, r_fcomp_k, r_fcomp_cnt, r_stall_err, r_max_out;
  bit r_timeout;
  int s_start_hi;
  bit s_dropped;

  cnn_layer_accel_job_driver #(
    .C_PIXEL_WIDTH (16),
    .C_NUM_CHANNELS(8),
    .C_ADDR_WIDTH  (AW),
    .C_DIM_WIDTH   (NW)
  ) dut (
    .clk_if            (clk_if),
    .rst               (rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_num_rows      (cmd_num_rows),
    .cmd_num_cols      (cmd_num_cols),
    .cmd_base_addr     (cmd_base_addr),
    .job_start         (job_start),
    .job_accept        (job_accept),
    .job_fetch_request (job_fetch_request),
    .job_fetch_ack     (job_fetch_ack),
    .job_fetch_complete(job_fetch_complete),
    .job_complete      (job_complete),
    .job_complete_ack  (job_complete_ack),
    .pixel_valid       (pixel_valid),
    .pixel_ready       (pixel_ready),
    .pixel_data        (pixel_data),
    .mem_rd_en         (mem_rd_en),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_data       (mem_rd_data),
    .job_done          (job_done),
    .err_overfetch     (err_overfetch)
  );

  always #5 clk_if = ~clk_if;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, ~a, a, ~a, a, ~a, 8'hC3};
  endfunction

  // input-map memory: data valid one cycle after the read strobe
  always @(posedge clk_if) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem_word(mem_rd_addr);
      rd_log.push_back(mem_rd_addr);
    end else begin
      mem_rd_data <= {8{16'hBAD0}};
    end
  end

  task automatic send_cmd(input int rows, input int cols, input logic [AW-1:0] base);
    cmd_num_rows  = NW'(rows);
    cmd_num_cols  = NW'(cols);
    cmd_base_addr = base;
    cmd_valid     = 1'b1;
    @(negedge clk_if);
    cmd_valid     = 1'b0;
  endtask

  task automatic start_job(input int delay);
    s_start_hi = 0;
    for (int i = 0; i < delay; i++) begin
      if (job_start) s_start_hi++;
      if (i == delay - 1) job_accept = 1'b1;
      @(negedge clk_if);
    end
    job_accept = 1'b0;
    s_dropped  = (job_start === 1'b0);
  endtask

  task automatic fetch_row(input bit rnd);
    bit            pv_prev, pr_prev;
    logic [DW-1:0] pd_prev;
    int            k, rd_base, outst;
    r_ack_k = 0; r_ack_cnt = 0; r_valid_k = 0; r_fcomp_k = 0; r_fcomp_cnt = 0;
    r_stall_err = 0; r_max_out = 0; r_timeout = 1'b1;
    beat_q.delete(); beat_k_q.delete();
    rd_base = rd_log.size();
    pv_prev = 1'b0; pr_prev = 1'b0; pd_prev = '0;
    job_fetch_request = 1'b1;
    k = 0;
    while (k < 200) begin
      @(negedge clk_if);
      k++;
      if (job_fetch_ack) begin
        r_ack_cnt++;
        if (r_ack_k == 0) r_ack_k = k;
        job_fetch_request = 1'b0;
      end
      if (pv_prev && !pr_prev && (!pixel_valid || pixel_data !== pd_prev)) r_stall_err++;
      if (pixel_valid && r_valid_k == 0) r_valid_k = k;
      if (job_fetch_complete) begin
        r_fcomp_cnt++;
        if (r_fcomp_k == 0) r_fcomp_k = k;
      end
      outst = rd_log.size() - rd_base - beat_q.size();
      if (outst > r_max_out) r_max_out = outst;
      if (r_fcomp_k != 0 && k > r_fcomp_k) begin
        r_timeout = 1'b0;
        break;
      end
      pixel_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pixel_valid && pixel_ready) begin
        beat_q.push_back(pixel_data);
        beat_k_q.push_back(k);
      end
      pv_prev = pixel_valid; pr_prev = pixel_ready; pd_prev = pixel_data;
    end
    pixel_ready       = 1'b0;
    job_fetch_request = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk_if);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_cmp++; if ({job_start, job_fetch_ack, job_fetch_complete, job_complete_ack, pixel_valid, mem_rd_en, job_done, err_overfetch} !== 8'h00) begin
      n_err++; $display("FAIL reset_pulses: got %b want 00000000", {job_start, job_fetch_ack, job_fetch_complete, job_complete_ack, pixel_valid, mem_rd_en, job_done, err_overfetch});
    end
    n_cmp++; if (mem_rd_addr !== '0 || pixel_data !== '0) begin n_err++; $display("FAIL reset_addr_data: got addr %0h data %0h want 0 0", mem_rd_addr, pixel_data); end
    rst = 1'b0;
    @(negedge clk_if);
  endtask

  task automatic test_basic;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL basic_idle_ready: got %b want 1", cmd_ready); end
    rd_log.delete();
    send_cmd(3, 4, 20'h00100);
    n_cmp++; if (cmd_ready !== 1'b0 || job_start !== 1'b1) begin n_err++; $display("FAIL basic_accept: got ready %b start %b want 0 1", cmd_ready, job_start); end
    start_job(5);
    n_cmp++; if (s_start_hi !== 5) begin n_err++; $display("FAIL basic_start_hold: got %0d want 5", s_start_hi); end
    n_cmp++; if (!s_dropped) begin n_err++; $display("FAIL basic_start_drop: got job_start %b want 0", job_start); end
    for (int r = 0; r < 3; r++) begin
      fetch_row(1'b0);
      n_cmp++; if (r_timeout) begin n_err++; $display("FAIL basic_row%0d_timeout: no job_fetch_complete within budget", r); end
      n_cmp++; if (r_ack_cnt !== 1) begin n_err++; $display("FAIL basic_row%0d_ack_len: got %0d want 1", r, r_ack_cnt); end
      n_cmp++; if (r_valid_k - r_ack_k !== 2) begin n_err++; $display("FAIL basic_row%0d_latency: got %0d want 2", r, r_valid_k - r_ack_k); end
      n_cmp++; if (beat_q.size() !== 4) begin n_err++; $display("FAIL basic_row%0d_beats: got %0d want 4", r, beat_q.size()); end
      for (int i = 0; i < beat_q.size(); i++) begin
        n_cmp++; if (beat_q[i] !== mem_word(AW'(32'h100 + r * 4 + i))) begin
          n_err++; $display("FAIL basic_row%0d_data%0d: got %0h want %0h", r, i, beat_q[i], mem_word(AW'(32'h100 + r * 4 + i)));
        end
      end
      if (beat_k_q.size() == 4) begin
        n_cmp++; if (beat_k_q[3] - beat_k_q[0] !== 3) begin n_err++; $display("FAIL basic_row%0d_contig: got span %0d want 3", r, beat_k_q[3] - beat_k_q[0]); end
      end
      n_cmp++; if (r_fcomp_cnt !== 1 || r_fcomp_k !== 7) begin n_err++; $display("FAIL basic_row%0d_fcomp: got len %0d at %0d want 1 at 7", r, r_fcomp_cnt, r_fcomp_k); end
    end
    n_cmp++; if (rd_log.size() !== 12) begin n_err++; $display("FAIL basic_reads: got %0d want 12", rd_log.size()); end
    for (int i = 0; i < rd_log.size() && i < 12; i++) begin
      n_cmp++; if (rd_log[i] !== AW'(32'h100 + i)) begin n_err++; $display("FAIL basic_addr%0d: got %0h want %0h", i, rd_log[i], 32'h100 + i); end
    end
    job_complete = 1'b1;
    @(negedge clk_if);
    job_complete = 1'b0;
    n_cmp++; if (job_complete_ack !== 1'b1 || job_done !== 1'b1) begin n_err++; $display("FAIL basic_cack: got ack %b done %b want 1 1", job_complete_ack, job_done); end
    @(negedge clk_if);
    n_cmp++; if (job_complete_ack !== 1'b0 || job_done !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL basic_close: got ack %b done %b ready %b want 0 0 1", job_complete_ack, job_done, cmd_ready);
    end
  endtask

  task automatic test_random_ready;
    rd_log.delete();
    send_cmd(3, 4, 20'h00100);
    start_job(1);
    for (int r = 0; r < 3; r++) begin
      fetch_row(1'b1);
      n_cmp++; if (r_timeout) begin n_err++; $display("FAIL rnd_row%0d_timeout: no job_fetch_complete within budget", r); end
      n_cmp++; if (r_ack_cnt !== 1) begin n_err++; $display("FAIL rnd_row%0d_ack_len: got %0d want 1", r, r_ack_cnt); end
      n_cmp++; if (beat_q.size() !== 4) begin n_err++; $display("FAIL rnd_row%0d_beats: got %0d want 4", r, beat_q.size()); end
      for (int i = 0; i < beat_q.size(); i++) begin
        n_cmp++; if (beat_q[i] !== mem_word(AW'(32'h100 + r * 4 + i))) begin
          n_err++; $display("FAIL rnd_row%0d_data%0d: got %0h want %0h", r, i, beat_q[i], mem_word(AW'(32'h100 + r * 4 + i)));
        end
      end
      n_cmp++; if (r_stall_err !== 0) begin n_err++; $display("FAIL rnd_row%0d_stall: got %0d unstable stalls want 0", r, r_stall_err); end
      n_cmp++; if (r_max_out > 2) begin n_err++; $display("FAIL rnd_row%0d_occupancy: got %0d outstanding want <=2", r, r_max_out); end
      n_cmp++; if (r_fcomp_cnt !== 1) begin n_err++; $display("FAIL rnd_row%0d_fcomp: got %0d want 1", r, r_fcomp_cnt); end
    end
    n_cmp++; if (rd_log.size() !== 12) begin n_err++; $display("FAIL rnd_reads: got %0d want 12", rd_log.size()); end
    job_complete = 1'b1;
    @(negedge clk_if);
    job_complete = 1'b0;
    @(negedge clk_if);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rnd_close: got ready %b want 1", cmd_ready); end
  endtask

  task automatic test_cols1_overfetch;
    int acks;
    send_cmd(2, 1, 20'h00040);
    start_job(1);
    for (int r = 0; r < 2; r++) begin
      fetch_row(1'b0);
      n_cmp++; if (r_ack_cnt !== 1) begin n_err++; $display("FAIL c1_row%0d_ack_len: got %0d want 1", r, r_ack_cnt); end
      n_cmp++; if (beat_q.size() !== 1) begin n_err++; $display("FAIL c1_row%0d_beats: got %0d want 1", r, beat_q.size()); end
      if (beat_q.size() > 0) begin
        n_cmp++; if (beat_q[0] !== mem_word(AW'(32'h40 + r))) begin n_err++; $display("FAIL c1_row%0d_data: got %0h want %0h", r, beat_q[0], mem_word(AW'(32'h40 + r))); end
      end
      n_cmp++; if (r_fcomp_cnt !== 1 || r_fcomp_k !== 4) begin n_err++; $display("FAIL c1_row%0d_fcomp: got len %0d at %0d want 1 at 4", r, r_fcomp_cnt, r_fcomp_k); end
    end
    n_cmp++; if (err_overfetch !== 1'b0) begin n_err++; $display("FAIL c1_err_early: got %b want 0", err_overfetch); end
    acks = 0;
    job_fetch_request = 1'b1;
    repeat (4) begin
      @(negedge clk_if);
      if (job_fetch_ack || pixel_valid) acks++;
    end
    job_fetch_request = 1'b0;
    n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL overfetch_ack: got %0d ack/valid cycles want 0", acks); end
    n_cmp++; if (err_overfetch !== 1'b1) begin n_err++; $display("FAIL overfetch_err: got %b want 1", err_overfetch); end
    job_complete = 1'b1;
    @(negedge clk_if);
    job_complete = 1'b0;
    n_cmp++; if (job_complete_ack !== 1'b1 || job_done !== 1'b1) begin n_err++; $display("FAIL overfetch_cack: got ack %b done %b want 1 1", job_complete_ack, job_done); end
    @(negedge clk_if);
    n_cmp++; if (cmd_ready !== 1'b1 || err_overfetch !== 1'b1) begin n_err++; $display("FAIL overfetch_sticky: got ready %b err %b want 1 1", cmd_ready, err_overfetch); end
    send_cmd(1, 1, 20'h00050);
    n_cmp++; if (err_overfetch !== 1'b0) begin n_err++; $display("FAIL overfetch_clear: got %b want 0", err_overfetch); end
    start_job(1);
    fetch_row(1'b0);
    job_complete = 1'b1;
    @(negedge clk_if);
    job_complete = 1'b0;
    @(negedge clk_if);
  endtask

  task automatic test_priority;
    int n_rd;
    send_cmd(2, 2, 20'h00300);
    start_job(1);
    n_rd = rd_log.size();
    job_complete = 1'b1;
    job_fetch_request = 1'b1;
    @(negedge clk_if);
    job_complete = 1'b0;
    job_fetch_request = 1'b0;
    n_cmp++; if (job_complete_ack !== 1'b1 || job_done !== 1'b1 || job_fetch_ack !== 1'b0) begin
      n_err++; $display("FAIL prio_cack: got cack %b done %b fack %b want 1 1 0", job_complete_ack, job_done, job_fetch_ack);
    end
    @(negedge clk_if);
    n_cmp++; if (cmd_ready !== 1'b1 || job_fetch_ack !== 1'b0 || job_complete_ack !== 1'b0) begin
      n_err++; $display("FAIL prio_idle: got ready %b fack %b cack %b want 1 0 0", cmd_ready, job_fetch_ack, job_complete_ack);
    end
    n_cmp++; if (rd_log.size() !== n_rd) begin n_err++; $display("FAIL prio_reads: got %0d reads want 0", rd_log.size() - n_rd); end
  endtask

  task automatic test_wrap;
    logic [AW-1:0] exp_a [4];
    exp_a[0] = 20'hFFFFE; exp_a[1] = 20'hFFFFF; exp_a[2] = 20'h00000; exp_a[3] = 20'h00001;
    rd_log.delete();
    send_cmd(1, 4, 20'hFFFFE);
    start_job(1);
    fetch_row(1'b0);
    n_cmp++; if (rd_log.size() !== 4 || beat_q.size() !== 4) begin n_err++; $display("FAIL wrap_count: got reads %0d beats %0d want 4 4", rd_log.size(), beat_q.size()); end
    for (int i = 0; i < 4 && i < rd_log.size() && i < beat_q.size(); i++) begin
      n_cmp++; if (rd_log[i] !== exp_a[i]) begin n_err++; $display("FAIL wrap_addr%0d: got %0h want %0h", i, rd_log[i], exp_a[i]); end
      n_cmp++; if (beat_q[i] !== mem_word(exp_a[i])) begin n_err++; $display("FAIL wrap_data%0d: got %0h want %0h", i, beat_q[i], mem_word(exp_a[i])); end
    end
    n_cmp++; if (err_overfetch !== 1'b0) begin n_err++; $display("FAIL wrap_err: got %b want 0", err_overfetch); end
    job_complete = 1'b1;
    @(negedge clk_if);
    job_complete = 1'b0;
    @(negedge clk_if);
  endtask

  task automatic test_reset_mid_stream;
    int beats, k, pulses;
    send_cmd(4, 8, 20'h00200);
    start_job(1);
    job_fetch_request = 1'b1;
    pixel_ready = 1'b1;
    beats = 0;
    k = 0;
    while (beats < 3 && k < 100) begin
      @(negedge clk_if);
      k++;
      if (job_fetch_ack) job_fetch_request = 1'b0;
      if (pixel_valid) beats++;
    end
    n_cmp++; if (beats !== 3) begin n_err++; $display("FAIL rstmid_beats: got %0d want 3", beats); end
    @(negedge clk_if);
    rst = 1'b1;
    pixel_ready = 1'b0;
    job_fetch_request = 1'b0;
    @(negedge clk_if);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b want 1", cmd_ready); end
    n_cmp++; if ({job_start, job_fetch_ack, job_fetch_complete, job_complete_ack, pixel_valid, mem_rd_en, job_done, err_overfetch} !== 8'h00) begin
      n_err++; $display("FAIL rstmid_pulses: got %b want 00000000", {job_start, job_fetch_ack, job_fetch_complete, job_complete_ack, pixel_valid, mem_rd_en, job_done, err_overfetch});
    end
    n_cmp++; if (mem_rd_addr !== '0 || pixel_data !== '0) begin n_err++; $display("FAIL rstmid_addr_data: got addr %0h data %0h want 0 0", mem_rd_addr, pixel_data); end
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk_if);
      if (job_fetch_complete || job_fetch_ack || pixel_valid || job_start || job_complete_ack || mem_rd_en) pulses++;
    end
    n_cmp++; if (pulses !== 0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_quiet: got %0d pulse cycles ready %b want 0 1", pulses, cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_ready();
    test_cols1_overfetch();
    test_priority();
    test_wrap();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
